// File: rtl/pcc_stream_acc.sv
// Streaming positive/negative popcount comparator: accumulates BEATS beats of
// saturating popcounts, then presents one registered decision over valid/ready.
module pcc_sat_acc #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_vec,
  output logic [ACC_W-1:0] o_acc_nxt,
  output logic             o_sat_nxt
);
  localparam int CW = $clog2(IN_W + 1);
  localparam int SW = ((CW > ACC_W) ? CW : ACC_W) + 1;
  localparam logic [SW-1:0] MAX = SW'((1 << ACC_W) - 1);

  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [CW-1:0]    w_pop;
  logic [SW-1:0]    w_sum;
  logic             w_clamp;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < IN_W; i++) w_pop = w_pop + CW'(i_vec[i]);
  end

  assign w_sum     = SW'(r_acc) + SW'(w_pop);
  assign w_clamp   = w_sum > MAX;
  assign o_acc_nxt = w_clamp ? MAX[ACC_W-1:0] : w_sum[ACC_W-1:0];
  assign o_sat_nxt = r_sat | w_clamp;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_acc <= o_acc_nxt;
      r_sat <= o_sat_nxt;
    end
  end
endmodule

module pcc_stream_acc #(
  parameter int POS_W = 2,
  parameter int NEG_W = 4,
  parameter int BEATS = 4,
  parameter int ACC_W = 4,
  parameter int BIAS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic [NEG_W-1:0] in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             outval,
  output logic [ACC_W-1:0] out_pos_cnt,
  output logic [ACC_W-1:0] out_neg_cnt,
  output logic             out_sat
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_ACC, S_OUT} state_t;
  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             w_fire, w_last, w_done, w_cmp;
  logic [ACC_W-1:0] w_pos_nxt, w_neg_nxt;
  logic             w_pos_sat, w_neg_sat;

  assign w_fire = in_valid & in_ready;
  assign w_last = (r_cnt == CNT_W'(BEATS - 1));
  assign w_done = (r_state == S_OUT) & out_ready;

  pcc_sat_acc #(.IN_W(POS_W), .ACC_W(ACC_W)) u_pos (
    .clk(clk), .rst(rst), .i_clr(w_done), .i_en(w_fire), .i_vec(in_pos),
    .o_acc_nxt(w_pos_nxt), .o_sat_nxt(w_pos_sat)
  );
  pcc_sat_acc #(.IN_W(NEG_W), .ACC_W(ACC_W)) u_neg (
    .clk(clk), .rst(rst), .i_clr(w_done), .i_en(w_fire), .i_vec(in_neg),
    .o_acc_nxt(w_neg_nxt), .o_sat_nxt(w_neg_sat)
  );

  // Decision is taken on the post-update accumulators of the final beat; ties win.
  assign w_cmp = ({1'b0, w_pos_nxt} + (ACC_W + 1)'(BIAS)) >= {1'b0, w_neg_nxt};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = ~rst;
        if (w_fire && w_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_ACC;
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_done)                r_cnt <= '0;
    else if (w_fire && w_last)        r_cnt <= '0;
    else if (w_fire)                  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outval      <= 1'b0;
      out_pos_cnt <= '0;
      out_neg_cnt <= '0;
      out_sat     <= 1'b0;
    end else if (w_fire && w_last) begin
      outval      <= w_cmp;
      out_pos_cnt <= w_pos_nxt;
      out_neg_cnt <= w_neg_nxt;
      out_sat     <= w_pos_sat | w_neg_sat;
    end
  end
endmodule

// File: tb/tb_pcc_stream_acc.sv
// Scoreboard bench for pcc_stream_acc: a BIAS=0 and a BIAS=5 instance share the
// stimulus; a monitor pops hand-computed expectations on each output handshake.
module tb_pcc_stream_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] in_pos = '0;
  logic [3:0] in_neg = '0;

  logic       in_ready, out_valid, outval, out_sat;
  logic [3:0] out_pos_cnt, out_neg_cnt;
  logic       in_ready_b, out_valid_b, outval_b, out_sat_b;
  logic [3:0] out_pos_cnt_b, out_neg_cnt_b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       o;
    logic [3:0] p;
    logic [3:0] n;
    logic       s;
    logic       ob;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pcc_stream_acc #(.POS_W(2), .NEG_W(4), .BEATS(4), .ACC_W(4), .BIAS(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid), .out_ready(out_ready),
    .outval(outval), .out_pos_cnt(out_pos_cnt), .out_neg_cnt(out_neg_cnt), .out_sat(out_sat)
  );

  pcc_stream_acc #(.POS_W(2), .NEG_W(4), .BEATS(4), .ACC_W(4), .BIAS(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid_b), .out_ready(out_ready),
    .outval(outval_b), .out_pos_cnt(out_pos_cnt_b), .out_neg_cnt(out_neg_cnt_b), .out_sat(out_sat_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=valid expected=none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("outval",      32'(outval),        32'(e.o));
        chk("out_pos_cnt", 32'(out_pos_cnt),   32'(e.p));
        chk("out_neg_cnt", 32'(out_neg_cnt),   32'(e.n));
        chk("out_sat",     32'(out_sat),       32'(e.s));
        chk("b_valid",     32'(out_valid_b),   32'd1);
        chk("b_outval",    32'(outval_b),      32'(e.ob));
        chk("b_pos_cnt",   32'(out_pos_cnt_b), 32'(e.p));
        chk("b_neg_cnt",   32'(out_neg_cnt_b), 32'(e.n));
      end
    end
  end

  task automatic send_beat(input logic [1:0] p, input logic [3:0] n);
    int t = 0;
    in_valid = 1'b1;
    in_pos   = p;
    in_neg   = n;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout in_ready=0 expected=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_pos   = '0;
    in_neg   = '0;
  endtask

  // One 4-beat group with identical beats; gap inserts idle cycles between beats.
  task automatic group(input logic [1:0] p, input logic [3:0] n,
                       input logic [3:0] ep, input logic [3:0] en,
                       input logic eo, input logic es, input logic eob, input int gap);
    exp_t e;
    e.o = eo; e.p = ep; e.n = en; e.s = es; e.ob = eob;
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      send_beat(p, n);
      if (i < 3) begin
        chk("early_valid", 32'(out_valid), 32'd0);
        repeat (gap) @(posedge clk);
        #1;
      end else begin
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("out_in_ready",  32'(in_ready),  32'd0);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),    32'd0);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_outval",    32'(outval),      32'd0);
    chk("rst_pos_cnt",   32'(out_pos_cnt), 32'd0);
    chk("rst_neg_cnt",   32'(out_neg_cnt), 32'd0);
    chk("rst_sat",       32'(out_sat),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    //     pos    neg      P      N     o     s     o(b5) gap
    group(2'b11, 4'b0011, 4'd8,  4'd8,  1'b1, 1'b0, 1'b1, 0);
    group(2'b11, 4'b0111, 4'd8,  4'd12, 1'b0, 1'b0, 1'b1, 0);
    group(2'b01, 4'b1111, 4'd4,  4'd15, 1'b0, 1'b1, 1'b0, 0);
    group(2'b00, 4'b0000, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 0);
    group(2'b11, 4'b1111, 4'd8,  4'd15, 1'b0, 1'b1, 1'b0, 0);
    group(2'b11, 4'b0011, 4'd8,  4'd8,  1'b1, 1'b0, 1'b1, 2);

    // Backpressure: hold the result while beats are offered and must be ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    group(2'b11, 4'b0111, 4'd8, 4'd12, 1'b0, 1'b0, 1'b1, 0);
    in_valid = 1'b1;
    in_pos   = 2'b11;
    in_neg   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid",    32'(out_valid),   32'd1);
      chk("hold_in_ready", 32'(in_ready),    32'd0);
      chk("hold_pos_cnt",  32'(out_pos_cnt), 32'd8);
      chk("hold_neg_cnt",  32'(out_neg_cnt), 32'd12);
      chk("hold_outval",   32'(outval),      32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid",    32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready),  32'd1);
    group(2'b01, 4'b0001, 4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 0);

    // Reset mid-group discards the partial accumulation without an output.
    @(posedge clk);
    #1;
    send_beat(2'b11, 4'b1111);
    send_beat(2'b11, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    group(2'b11, 4'b0001, 4'd8, 4'd4, 1'b1, 1'b0, 1'b1, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pcc_stream_acc.md
Name: pcc_stream_acc

Overview:
- Sequential, parametrised successor to the single-shot positive/negative popcount comparator.
- Accepts a stream of positive and negative bit vectors, BEATS vectors per decision.
- Per beat: computes exact popcounts and adds them to saturating accumulators.
- After the last beat of a group, emits one registered decision (pos_count + BIAS >= neg_count) with a valid/ready handshake. Sits between the feature/bit-stream producer and the classifier vote logic.

Parameters:
- POS_W, 2, width of the positive input vector per beat
- NEG_W, 4, width of the negative input vector per beat
- BEATS, 4, beats accumulated per decision (>=1)
- ACC_W, 4, accumulator width; both accumulators saturate at 2^ACC_W-1
- BIAS, 0, unsigned constant added to the positive count before compare (< 2^ACC_W)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  beat present on in_pos/in_neg
- in_ready  output  1  block can accept a beat
- in_pos  input  POS_W  positive bit vector
- in_neg  input  NEG_W  negative bit vector
- out_valid  output  1  decision valid
- out_ready  input  1  consumer accepts decision
- outval  output  1  1 when (pos_acc + BIAS) >= neg_acc
- out_pos_cnt  output  ACC_W  final saturated positive accumulator
- out_neg_cnt  output  ACC_W  final saturated negative accumulator
- out_sat  output  1  either accumulator saturated during the group

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values (rst high at an edge):
  - state=ACC, beat counter=0, both accumulators=0, sat flags=0.
  - out_valid=0, outval=0, out_pos_cnt=0, out_neg_cnt=0, out_sat=0.
  - in_ready is 0 while rst is high.
  - rst takes priority over every other event, including mid-group and while holding a result. A partial group is discarded with no output.
- States:
  - ACC: in_ready=1. A beat transfers when in_valid&in_ready.
    - pos_acc <= sat(pos_acc + popcount(in_pos)); neg_acc likewise; beat counter +1.
    - If this is beat BEATS-1, go to OUT next cycle.
  - OUT: out_valid=1, in_ready=0. Output fields are registered at the ACC->OUT transition and stay stable until the handshake.
    - When out_ready=1 at an edge: out_valid <= 0, accumulators, counter and sat flags <= 0, go to ACC.
- Latency: out_valid rises on the edge that accepts beat BEATS, so it is visible the cycle after that beat's handshake.
- Throughput: at least 1 bubble cycle per group, since in_ready is low in OUT, including the handshake cycle.
  - Max rate: BEATS beats per BEATS+1 cycles with out_ready tied high.
- Arithmetic:
  - popcount is exact.
  - Addition uses ACC_W+1 bits and clamps to 2^ACC_W-1. A clamp sets the respective sticky sat flag.
  - out_sat = pos_sat | neg_sat.
  - Compare uses ACC_W+1 bits: {0,pos_acc}+BIAS >= {0,neg_acc}, unsigned. Ties give outval=1.
- Boundaries:
  - in_valid low in ACC holds all state.
  - Input values are ignored while in_ready=0.
  - BEATS=1 gives one beat per decision.
  - Beat counter width is clog2(BEATS) (min 1) and never wraps past BEATS-1.
  - out_ready high outside OUT has no effect.
- Equivalence: with BEATS=1, ACC_W>=3, BIAS=0 and default widths, outval equals the single-shot comparator for every input pair.

Test Plan:
- Reset, then 4 beats of pos=2'b11, neg=4'b0011, out_ready=1:
  - out_valid exactly one cycle after the 4th accept.
  - out_pos_cnt=8, out_neg_cnt=8, outval=1, out_sat=0.
- 4 beats of pos=2'b11, neg=4'b0111: neg=12, pos=8, outval=0.
- Saturation, 4 beats of pos=2'b01, neg=4'b1111: out_neg_cnt=15, out_pos_cnt=4, out_sat=1, outval=0.
  - The next group of 4×(2'b00, 4'b0000) gives counts 0/0, out_sat=0, outval=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - Outputs stable, in_ready=0, in_valid beats presented are not counted.
  - Release: out_valid drops the next edge, then in_ready=1.
- Reset mid-group: accept 2 beats of (2'b11, 4'b1111), assert rst 1 cycle, then 4 beats of (2'b11, 4'b0001).
  - Output pos=8, neg=4, outval=1.
- BIAS=5 build: 4 beats of (2'b11, 4'b0111) gives 8+5 >= 12, so outval=1. With neg=4'b1111 (saturated 15), outval=0.
